// File: rtl/muldiv_ctrl.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiply and restoring divide.
// Optional macro MULDIV_ZERO_SKIP_EN bypasses CALC for zero multiply operands or a zero divisor.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            flush,
    output logic            busy,
    output logic            stallreq,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

    state_t              state_r;
    state_t              state_s;
    logic [5:0]          cnt_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [XLEN-1:0]     opr_r;
    logic [2:0]          op_r;
    logic                neg_res_r;
    logic                neg_rem_r;
    logic [XLEN-1:0]     result_r;

    logic                sa_s;
    logic                sb_s;
    logic                b_zero_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic                neg_res_s;
    logic                neg_rem_s;
    logic [2*XLEN-1:0]   acc_init_s;
    logic [XLEN-1:0]     opr_init_s;
    logic                skip_s;

    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       rem_ext_s;
    logic [XLEN+1:0]     diff_s;
    logic [2*XLEN-1:0]   acc_step_s;

    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     fix_sel_s;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic en);
        if (en) begin
            cneg = ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            cneg = v;
        end
    endfunction

    // Operand decode at issue: magnitudes, result signs and accumulator preload.
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (op)
            3'd1, 3'd4, 3'd6: begin
                sa_s = opa[XLEN-1];
                sb_s = opb[XLEN-1];
            end
            3'd2:    sa_s = opa[XLEN-1];
            default: sa_s = 1'b0;
        endcase
        mag_a_s  = cneg(opa, sa_s);
        mag_b_s  = cneg(opb, sb_s);
        b_zero_s = (opb == {XLEN{1'b0}});
        // A zero divisor keeps the quotient positive so the raw all-ones quotient survives FIX.
        if (op[2]) begin
            neg_res_s  = (sa_s ^ sb_s) & ~b_zero_s;
            neg_rem_s  = sa_s;
            acc_init_s = {{XLEN{1'b0}}, mag_a_s};
            opr_init_s = mag_b_s;
        end else begin
            neg_res_s  = sa_s ^ sb_s;
            neg_rem_s  = 1'b0;
            acc_init_s = {{XLEN{1'b0}}, mag_b_s};
            opr_init_s = mag_a_s;
        end
        skip_s = 1'b0;
`ifdef MULDIV_ZERO_SKIP_EN
        if (op[2]) begin
            if (b_zero_s) begin
                skip_s     = 1'b1;
                acc_init_s = {mag_a_s, {XLEN{1'b1}}};
            end else begin
                skip_s = 1'b0;
            end
        end else if ((opa == {XLEN{1'b0}}) || b_zero_s) begin
            skip_s     = 1'b1;
            acc_init_s = {(2*XLEN){1'b0}};
        end else begin
            skip_s = 1'b0;
        end
`endif
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                    (acc_r[0] ? {1'b0, opr_r} : {(XLEN+1){1'b0}});
        rem_ext_s = acc_r[2*XLEN-1:XLEN-1];
        diff_s    = {1'b0, rem_ext_s} - {2'b00, opr_r};
        if (op_r[2]) begin
            if (diff_s[XLEN+1]) begin
                acc_step_s = {rem_ext_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end else begin
                acc_step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection.
    always_comb begin
        if (neg_res_r) begin
            prod_s = ~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc_r;
        end
        quot_s = cneg(acc_r[XLEN-1:0], neg_res_r);
        rem_s  = cneg(acc_r[2*XLEN-1:XLEN], neg_rem_r);
        case (op_r)
            3'd0:             fix_sel_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_sel_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_sel_s = quot_s;
            default:          fix_sel_s = rem_s;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; flush wins over everything.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_s = skip_s ? S_FIX : S_CALC;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cnt_r == LAST_STEP) begin
                        state_s = S_FIX;
                    end else begin
                        state_s = S_CALC;
                    end
                end
                S_FIX:   state_s = S_DONE;
                S_DONE:  state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Output decode.
    always_comb begin
        busy     = (state_r != S_IDLE);
        done     = (state_r == S_DONE);
        stallreq = ((state_r == S_IDLE) && start && !flush) ||
                   (state_r == S_CALC) || (state_r == S_FIX);
    end

    // Datapath registers: operand latch, iteration and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= 6'd0;
            acc_r     <= {(2*XLEN){1'b0}};
            opr_r     <= {XLEN{1'b0}};
            op_r      <= 3'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_r      <= op;
                        acc_r     <= acc_init_s;
                        opr_r     <= opr_init_s;
                        neg_res_r <= neg_res_s;
                        neg_rem_r <= neg_rem_s;
                        cnt_r     <= 6'd0;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        acc_r <= acc_step_s;
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        result_r <= fix_sel_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed RV32M cases plus randomized ops vs a 64-bit arithmetic model.
module tb_muldiv_ctrl;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        busy;
    logic        stallreq;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .flush(flush), .busy(busy), .stallreq(stallreq), .done(done), .result(result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result computed with wide arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
            3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; p = 64'(ua / ub); return p[31:0]; end
            3'd6: begin if (b == 32'd0) return a; p = 64'(sa % sb); return p[31:0]; end
            default: begin if (b == 32'd0) return a; p = 64'(ua % ub); return p[31:0]; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_SKIP_EN
        if (o[2] && b == 32'd0) return 2;
        if (!o[2] && (a == 32'd0 || b == 32'd0)) return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one op at the current negedge and follow it to done; hold keeps start high (with new operands) early on.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit hold);
        int          k;
        logic        stall_ok;
        logic        hold_ok;
        logic [31:0] prev;
        prev = result;
        op = o; opa = a; opb = b; start = 1'b1;
        #1;
        check({tag, ":stall0"}, {31'd0, stallreq}, 32'd1);
        k = 0; stall_ok = 1'b1; hold_ok = 1'b1;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) break;
            if (stallreq !== 1'b1) stall_ok = 1'b0;
            if (result !== prev) hold_ok = 1'b0;
            if (hold && k < 4) begin
                opa = 32'd100; opb = 32'd3; op = 3'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ":lat"}, 32'(k), 32'(exp_lat(o, a, b)));
        check({tag, ":result"}, result, exp);
        check({tag, ":stall_done"}, {31'd0, stallreq}, 32'd0);
        check({tag, ":stall_run"}, {31'd0, stall_ok}, 32'd1);
        check({tag, ":hold"}, {31'd0, hold_ok}, 32'd1);
        @(negedge clk);
        check({tag, ":done_1cyc"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  ro;
        logic        seen_done;

        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; opa = 32'd0; opb = 32'd0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("mul7x6",   3'd0, 32'd7,          32'd6,          32'h0000_002A, 1'b0);
        run_op("mulh_m1",  3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 1'b0);
        run_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 1'b0);
        run_op("div_m7",   3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0);
        run_op("rem_m7",   3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0);
        run_op("divu",     3'd5, 32'd100,        32'd7,          32'd14,        1'b0);
        run_op("remu",     3'd7, 32'd100,        32'd7,          32'd2,         1'b0);
        run_op("div_z",    3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0);
        run_op("rem_z",    3'd6, 32'd5,          32'd0,          32'd5,         1'b0);
        run_op("rem_zneg", 3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 1'b0);
        run_op("div_ovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0);
        run_op("rem_ovf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         1'b0);
        run_op("mul_zero", 3'd0, 32'd1234,       32'd0,          32'd0,         1'b0);
        run_op("start_busy", 3'd0, 32'd7,        32'd6,          32'h0000_002A, 1'b1);

        // Flush at cycle 10 of a DIV, then restart at cycle 11.
        prev = result;
        op = 3'd4; opa = 32'd1000; opb = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_done = 1'b0;
        repeat (9) begin
            if (done === 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {31'd0, busy}, 32'd0);
        check("flush_no_done", {30'd0, done, seen_done}, 32'd0);
        check("flush_result_kept", result, prev);
        run_op("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 1'b0);

        // Asynchronous reset at cycle 20 of a MUL.
        op = 3'd0; opa = 32'd7; opb = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op("after_rst", 3'd1, 32'hFFFF_FFF9, 32'd3, ref_res(3'd1, 32'hFFFF_FFF9, 32'd3), 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op("rand", ro, ra, rb, ref_res(ro, ra, rb), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle sequencer for the RV32M multiply/divide operations that sit beside the single-cycle ALU in the execute stage. It accepts an operation and two operands from `ex`, then runs a 32-step shift-add multiply or restoring divide on an internal datapath. It raises a stall request to the pipeline controller while it works and presents a one-cycle result strobe for `ex` to route to `wdata_o` and the forwarding path.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (iteration count equals `XLEN`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `opa`  in  XLEN  rs1 value (dividend / multiplicand).
- `opb`  in  XLEN  rs2 value (divisor / multiplier).
- `flush`  in  1  abort current operation (branch redirect / pipeline flush).
- `busy`  out  1  state is not IDLE.
- `stallreq`  out  1  combinational stall request to the pipeline controller.
- `done`  out  1  one-cycle strobe; `result` is valid.
- `result`  out  XLEN  final result; holds until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE. 6-bit step counter, 2×XLEN accumulator, XLEN operand register, sign flags, op latch.
- IDLE: on `start=1` and `flush=0`, latch `op` and the operand magnitudes. Signed ops take the two's-complement magnitude of each signed operand (MULHSU: `opa` only). Record `neg_res` and `neg_rem`. Clear the counter and go to CALC.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper accumulator half. Then shift right by 1.
- CALC, divide: each cycle, shift {rem,quot} left by 1 and trial-subtract the divisor from rem. If there is no borrow, keep the difference and set quot LSB to 1.
- CALC leaves for FIX after step XLEN-1 (counter == 31).
- FIX: conditionally negate the 2×XLEN product when `neg_res` is set. Negate the quotient when `neg_res` is set, and the remainder when `neg_rem` is set (remainder sign follows the dividend). Select the output:
  - MUL → low half.
  - MULH, MULHSU, MULHU → high half.
  - DIV, DIVU → quotient.
  - REM, REMU → remainder.
  Register the selection into `result`. Go to DONE.
- Divide by zero: the quotient is forced to all-ones and the remainder to `opa`, for both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. The magnitude path produces this with no special case.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- `flush=1` in any state: next state IDLE. `done` is not asserted and `result` is unchanged. Flush has priority over `start`.
- `start` while `busy`: ignored.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `result=0`, counter 0.
- Reset mid-operation: everything returns to the reset values immediately (asynchronous). No `done` is issued.
- `stallreq` = (IDLE & `start` & ~`flush`) | CALC | FIX. It is deasserted in DONE so the stage advances with the result on that cycle.
- Latency: with `start` accepted at cycle 0, CALC occupies cycles 1–32, FIX is cycle 33, and `done` is high in cycle 34.
- Back-to-back: a new `start` is accepted in the cycle after DONE (IDLE). Minimum issue interval is 35 cycles.
- `result` changes only on the FIX→DONE transition.

## Configuration
- `MULDIV_ZERO_SKIP_EN` defined:
  - In IDLE, if either multiply operand is 0, or the divisor is 0, skip CALC and go directly to FIX with the accumulator preloaded for the architectural result.
  - `done` then rises at cycle 2.
  - `stallreq` covers only cycle 0 and FIX.
- Not defined: every operation takes the full 34-cycle path. Results are bit-identical either way.

## Test plan
- MUL 7 × 6 → `done` at cycle 34, `result`=0x0000002A, `stallreq` high cycles 0–33.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM 0x80000000 / 0xFFFFFFFF → 0.
- `flush` at cycle 10 of a DIV → IDLE at cycle 11, no `done`, `result` keeps its prior value, a new `start` at cycle 11 is accepted.
- `rst` pulsed low at cycle 20 of a MUL → `busy`, `done`, and `result` read 0 immediately. With `MULDIV_ZERO_SKIP_EN`, MUL x × 0 gives `done` at cycle 2 and `result`=0.
